// File: rtl/ads1292_sample_fifo_if.sv
// Sample handshake bundle between ads1292_filter, the sample FIFO and sensor_core.
// The producer side (in_*) and consumer side (out_*) are both carried here;
// the FIFO takes the slave view, the surrounding logic takes the master view.
interface ads1292_sample_fifo_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ack;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ack;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ack,
        output out_data,
        output out_valid,
        input  out_ack
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ack,
        input  out_data,
        input  out_valid,
        output out_ack
    );
endinterface

// File: rtl/ads1292_sample_fifo.sv
// Elastic sample buffer between ads1292_filter and sensor_core (i_CLK domain).
// Show-ahead register-array FIFO with a registered head, a two-state capture FSM
// that takes exactly one sample per VALID level, occupancy and overflow reporting.
// Optional build macro ADS1292_FIFO_DROP_OLDEST_EN: when full, discard the oldest
// entry instead of stalling the producer, and count the drops.
module ads1292_sample_fifo #(
    parameter  int DATA_WIDTH = 24,
    parameter  int DEPTH      = 16,
    parameter  int CNT_WIDTH  = 16,
    localparam int LVL_W      = $clog2(DEPTH + 1),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                   i_CLK,
    input  logic                   i_RSTN,
    ads1292_sample_fifo_if.slave   fifo_bus,
    input  logic                   i_FLUSH,
    output logic [LVL_W-1:0]       o_LEVEL,
    output logic                   o_FULL,
    output logic [CNT_WIDTH-1:0]   o_OVERFLOW_CNT
);

    typedef enum logic {
        ARMED    = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    state_t                state;
    logic                  in_ack_r;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [PTR_W-1:0]      rptr_n;
    logic [LVL_W-1:0]      level;
    logic [LVL_W-1:0]      level_n;
    logic                  full_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [DATA_WIDTH-1:0] out_data_n;

    logic                  pop;
    logic                  write_ok;
    logic                  capture;
    logic                  store;
    logic                  drop;
    logic                  rd_adv;

    // Handshake decode and next-state datapath values
    always_comb begin
        pop      = fifo_bus.out_ack && out_valid_r;
`ifdef ADS1292_FIFO_DROP_OLDEST_EN
        write_ok = 1'b1;
`else
        write_ok = !full_r || pop;
`endif
        capture  = (state == ARMED) && fifo_bus.in_valid && write_ok;
        // A flush discards the captured sample but the ack is still issued
        store    = capture && !i_FLUSH;
`ifdef ADS1292_FIFO_DROP_OLDEST_EN
        drop     = store && full_r && !pop;
`else
        drop     = 1'b0;
`endif
        rd_adv   = (pop && !i_FLUSH) || drop;

        if (i_FLUSH) begin
            rptr_n  = '0;
            level_n = '0;
        end else begin
            rptr_n  = rptr + PTR_W'(rd_adv);
            level_n = level + LVL_W'(store) - LVL_W'(rd_adv);
        end

        // The head register looks at the next read slot; when that slot is being
        // written in this same cycle (empty FIFO, or pop of the last entry) the
        // incoming sample is forwarded into the register, one cycle of latency.
        if (store && (wptr == rptr_n)) begin
            out_data_n = fifo_bus.in_data;
        end else begin
            out_data_n = mem[rptr_n];
        end
    end

    // Capture FSM: one sample per VALID assertion, acknowledged with a single pulse
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state    <= ARMED;
            in_ack_r <= 1'b0;
        end else begin
            in_ack_r <= capture;
            case (state)
                ARMED:    if (capture)            state <= WAIT_LOW;
                WAIT_LOW: if (!fifo_bus.in_valid) state <= ARMED;
                default:                          state <= ARMED;
            endcase
        end
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge i_CLK) begin
        if (store) begin
            mem[wptr] <= fifo_bus.in_data;
        end
    end

    // Pointers, occupancy and registered head/status outputs
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            full_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            if (i_FLUSH) begin
                wptr <= '0;
            end else if (store) begin
                wptr <= wptr + PTR_W'(1);
            end
            rptr        <= rptr_n;
            level       <= level_n;
            full_r      <= (level_n == LVL_W'(DEPTH));
            out_valid_r <= (level_n != '0);
            out_data_r  <= out_data_n;
        end
    end

`ifdef ADS1292_FIFO_DROP_OLDEST_EN
    logic [CNT_WIDTH-1:0] ovf_cnt;

    // Saturating count of discarded oldest entries; only reset clears it
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_OVERFLOW_CNT = ovf_cnt;
`else
    assign o_OVERFLOW_CNT = '0;
`endif

    assign fifo_bus.in_ack    = in_ack_r;
    assign fifo_bus.out_valid = out_valid_r;
    assign fifo_bus.out_data  = out_data_r;
    assign o_LEVEL            = level;
    assign o_FULL             = full_r;

endmodule

// File: doc/ads1292_sample_fifo.md
Name: ads1292_sample_fifo

Overview:
- Elastic buffer between ads1292_filter (producer, valid/ack) and sensor_core (consumer, valid/ack).
- Absorbs bursts of filtered ECG samples while the core is busy with the UART or MPR121.
- Keeps the filter from stalling and reports occupancy and sample loss.
- Runs in the i_CLK domain, same as ads1292_filter.

Parameters:
- DATA_WIDTH, 24: sample width in bits.
- DEPTH, 16: number of entries; power of two, at least 2.
- CNT_WIDTH, 16: width of the saturating overflow counter.

Ports:
- i_CLK  in  1  system clock.
- i_RSTN  in  1  reset; asynchronous, active-low.
- i_IN_DATA  in  DATA_WIDTH  filtered sample from ads1292_filter.
- i_IN_VALID  in  1  level; sample available, held by the producer until acked.
- o_IN_ACK  out  1  one-cycle pulse; sample captured.
- o_OUT_DATA  out  DATA_WIDTH  head-of-FIFO sample; show-ahead.
- o_OUT_VALID  out  1  FIFO non-empty.
- i_OUT_ACK  in  1  one-cycle pulse from the consumer; pop head.
- i_FLUSH  in  1  synchronous clear of contents.
- o_LEVEL  out  $clog2(DEPTH+1)  current occupancy.
- o_FULL  out  1  level == DEPTH.
- o_OVERFLOW_CNT  out  CNT_WIDTH  samples dropped; saturating.

Behaviour:
- Reset (i_RSTN low, asynchronous) forces these values. Reset mid-transfer discards all contents and does not generate an ack.
  - o_IN_ACK = 0, o_OUT_VALID = 0, o_OUT_DATA = 0.
  - o_LEVEL = 0, o_FULL = 0, o_OVERFLOW_CNT = 0.
  - Read and write pointers = 0, armed flag = 1.
- Storage: DEPTH x DATA_WIDTH register array. Read and write pointers are log2(DEPTH) bits and wrap naturally. Level is a separate counter.
- Input capture FSM has two states, ARMED and WAIT_LOW.
  - ARMED with i_IN_VALID = 1 and a write permitted:
    - write i_IN_DATA at the write pointer and increment the pointer;
    - pulse o_IN_ACK for exactly one cycle;
    - go to WAIT_LOW.
  - WAIT_LOW: no capture. Return to ARMED on the first cycle i_IN_VALID is sampled 0. This prevents a held VALID from being captured twice.
  - A write is permitted when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
  - When no write is permitted, VALID stays pending: no ack, the producer stalls, the state stays ARMED.
- Output side:
  - o_OUT_VALID = (level != 0).
  - o_OUT_DATA is registered and always equals the head entry.
  - i_OUT_ACK with o_OUT_VALID = 1 pops the head.
  - i_OUT_ACK while empty is ignored: no pointer change, no underflow.
  - If a pop and a write coincide, the level is unchanged and o_OUT_DATA advances to the next entry.
- Latency: a sample captured in cycle N while the FIFO is empty gives o_OUT_VALID = 1 and o_OUT_DATA = sample in cycle N+1. Bypass through an empty FIFO is never combinational.
- o_FULL and o_LEVEL are registered and updated in the same cycle as the pointers.
- i_FLUSH has priority over a simultaneous write or pop.
  - Pointers and level go to 0 the next cycle; o_OUT_VALID drops.
  - An input captured in the flush cycle is discarded, but its ack is still given.
  - The FSM state and o_OVERFLOW_CNT are unaffected.
- o_OVERFLOW_CNT saturates at 2^CNT_WIDTH-1. It is cleared only by reset.

Optional Feature:
- Macro: ADS1292_FIFO_DROP_OLDEST_EN.
- Defined: while full with no pop in the same cycle, an ARMED valid input is still accepted and acked.
  - The oldest entry is discarded: the read pointer increments, the level stays DEPTH.
  - o_OUT_DATA shows the new head.
  - o_OVERFLOW_CNT increments by 1, saturating.
  - The producer never stalls.
- Undefined: stall-when-full as described in Behaviour; o_OVERFLOW_CNT is tied to 0.

Test Plan:
- Reset, then one sample 0x123456 with VALID held 5 cycles:
  - exactly one o_IN_ACK;
  - next cycle o_OUT_VALID = 1, o_OUT_DATA = 0x123456, o_LEVEL = 1;
  - no second capture until VALID toggles low.
- Push 16 samples 0x000001..0x000010 with no pops:
  - o_FULL = 1, o_LEVEL = 16.
  - A 17th sample 0x000011 gets no ack (stall build).
  - After one i_OUT_ACK, 0x000011 is acked in the same cycle, level stays 16, o_OUT_DATA = 0x000002.
- Drop-oldest build, 20 samples 0x1..0x14 with no pops:
  - o_OVERFLOW_CNT = 4;
  - popping 16 times yields 0x5..0x14 in order.
- i_OUT_ACK pulses while empty: pointers, level and o_OUT_VALID unchanged.
- FIFO holding 3 entries:
  - i_FLUSH coinciding with a valid input gives an ack;
  - next cycle o_LEVEL = 0, o_OUT_VALID = 0.
- i_RSTN asserted with 8 entries and VALID high:
  - all outputs go to reset values immediately (asynchronously);
  - after release, the pending VALID is captured as a fresh sample.
